// File: rtl/bist_signature_checker.sv
// bist_signature_checker
//   Response-checking back end of the c432 logic-BIST loop. Every cycle the
//   applied pattern N and MISR signature s are matched against a small
//   programmable golden table. The result (found + selected entry) is
//   registered. Enabled cycles with no full match are counted, and a sticky
//   error is raised once the count exceeds MAX_MISS.
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   en                  : checking enable (count misses only when high)
//   N[35:0], s[3:0]     : applied pattern / current signature
//   wr_en, wr_addr,
//   wr_N, wr_s          : golden-table write port (wr_addr >= DEPTH ignored)
//   found               : previous cycle's (N,s) matched a valid entry
//   memory_N, memory_s  : contents of the selected entry (zero if none)
//   miss_count          : saturating count of enabled unmatched cycles
//   error               : sticky, miss_count exceeded MAX_MISS

// One golden entry: storage plus its own comparators.
module bist_golden_entry (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [35:0] i_wr_N,
  input  logic [3:0]  i_wr_s,
  input  logic [35:0] i_N,
  input  logic [3:0]  i_s,
  output logic        o_hitN,
  output logic        o_hit,
  output logic [35:0] o_pat,
  output logic [3:0]  o_sig
);
  logic        r_vld;
  logic [35:0] r_pat;
  logic [3:0]  r_sig;

  // Only the valid bit needs reset; pat/sig are qualified by it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= 1'b0;
    end else if (i_we) begin
      r_vld <= 1'b1;
      r_pat <= i_wr_N;
      r_sig <= i_wr_s;
    end
  end

  // Lookup sees the pre-write contents, so a same-cycle write lands next cycle.
  assign o_hitN = r_vld && (r_pat == i_N);
  assign o_hit  = o_hitN && (r_sig == i_s);
  assign o_pat  = r_pat;
  assign o_sig  = r_sig;
endmodule

module bist_signature_checker #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int MAX_MISS = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [35:0]      N,
  input  logic [3:0]       s,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [35:0]      wr_N,
  input  logic [3:0]       wr_s,
  output logic             found,
  output logic [35:0]      memory_N,
  output logic [3:0]       memory_s,
  output logic [CNT_W-1:0] miss_count,
  output logic             error
);
  logic [DEPTH-1:0]       w_hitN;
  logic [DEPTH-1:0]       w_hit;
  logic [DEPTH-1:0][35:0] w_pat;
  logic [DEPTH-1:0][3:0]  w_sig;

  logic             w_found_nxt;
  logic [35:0]      w_sel_N;
  logic [3:0]       w_sel_s;
  logic [CNT_W-1:0] w_miss_nxt;

  logic             r_found;
  logic [35:0]      r_memory_N;
  logic [3:0]       r_memory_s;
  logic [CNT_W-1:0] r_miss_count;
  logic             r_error;

  // Entries only decode addresses 0..DEPTH-1, so out-of-range writes
  // select nothing and are dropped.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    bist_golden_entry u_ent (
      .clk    (clk),
      .rst    (rst),
      .i_we   (wr_en && (wr_addr == AW'(i))),
      .i_wr_N (wr_N),
      .i_wr_s (wr_s),
      .i_N    (N),
      .i_s    (s),
      .o_hitN (w_hitN[i]),
      .o_hit  (w_hit[i]),
      .o_pat  (w_pat[i]),
      .o_sig  (w_sig[i])
    );
  end

  assign w_found_nxt = |w_hit;

  // Descending scans so the lowest index wins; the full-hit scan runs last
  // so any full hit overrides a pattern-only hit.
  always_comb begin
    w_sel_N = '0;
    w_sel_s = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (w_hitN[i]) begin
        w_sel_N = w_pat[i];
        w_sel_s = w_sig[i];
      end
    end
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_sel_N = w_pat[i];
        w_sel_s = w_sig[i];
      end
    end
  end

  // Saturating miss counter.
  always_comb begin
    w_miss_nxt = r_miss_count;
    if (en && !w_found_nxt && !(&r_miss_count))
      w_miss_nxt = r_miss_count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_found      <= 1'b0;
      r_memory_N   <= '0;
      r_memory_s   <= '0;
      r_miss_count <= '0;
      r_error      <= 1'b0;
    end else begin
      r_found      <= w_found_nxt;
      r_memory_N   <= w_sel_N;
      r_memory_s   <= w_sel_s;
      r_miss_count <= w_miss_nxt;
      // Compare against the next count so error rises on the same edge.
      r_error      <= r_error | (w_miss_nxt > CNT_W'(MAX_MISS));
    end
  end

  assign found      = r_found;
  assign memory_N   = r_memory_N;
  assign memory_s   = r_memory_s;
  assign miss_count = r_miss_count;
  assign error      = r_error;
endmodule

// File: tb/tb_bist_signature_checker.sv
module tb_bist_signature_checker;
  localparam int DEPTH = 16;
  localparam int AW    = 5;   // wide enough to present wr_addr = 20
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst, en, wr_en;
  logic [35:0]      N, wr_N;
  logic [3:0]       s, wr_s;
  logic [AW-1:0]    wr_addr;
  logic             found, error;
  logic [35:0]      memory_N;
  logic [3:0]       memory_s;
  logic [CNT_W-1:0] miss_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bist_signature_checker #(.DEPTH(DEPTH), .AW(AW), .MAX_MISS(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .N(N), .s(s),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_N(wr_N), .wr_s(wr_s),
    .found(found), .memory_N(memory_N), .memory_s(memory_s),
    .miss_count(miss_count), .error(error)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [35:0] pn, input logic [3:0] ps);
    wr_en = 1'b1; wr_addr = a; wr_N = pn; wr_s = ps;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_N = '0; wr_s = '0;
    N = '0; s = '0;
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("rst_found", 64'(found), 64'd0);
    chk("rst_memN",  64'(memory_N), 64'd0);
    chk("rst_mems",  64'(memory_s), 64'd0);
    chk("rst_miss",  64'(miss_count), 64'd0);
    chk("rst_err",   64'(error), 64'd0);

    wr(0, 36'h0_0000_0001, 4'hA);

    en = 1'b1; N = 36'h1; s = 4'hA;
    step();
    chk("hit_found", 64'(found), 64'd1);
    chk("hit_memN",  64'(memory_N), 64'h1);
    chk("hit_mems",  64'(memory_s), 64'hA);
    chk("hit_miss",  64'(miss_count), 64'd0);

    s = 4'h3;
    step();
    chk("sigbad_found", 64'(found), 64'd0);
    chk("sigbad_memN",  64'(memory_N), 64'h1);
    chk("sigbad_mems",  64'(memory_s), 64'hA);
    chk("sigbad_miss",  64'(miss_count), 64'd1);
    chk("sigbad_err",   64'(error), 64'd0);

    N = 36'h2; s = 4'h0;
    step();
    chk("miss2_cnt",  64'(miss_count), 64'd2);
    chk("miss2_err",  64'(error), 64'd0);
    chk("miss2_memN", 64'(memory_N), 64'd0);
    step();
    chk("miss3_cnt", 64'(miss_count), 64'd3);
    chk("miss3_err", 64'(error), 64'd1);

    N = 36'h1; s = 4'hA;
    step();
    chk("resume_found", 64'(found), 64'd1);
    chk("resume_miss",  64'(miss_count), 64'd3);
    chk("sticky_err",   64'(error), 64'd1);

    // Same-cycle write to the looked-up entry: old contents still match.
    wr(0, 36'h1, 4'hB);
    chk("coll_found", 64'(found), 64'd1);
    chk("coll_miss",  64'(miss_count), 64'd3);
    step();
    chk("coll2_found", 64'(found), 64'd0);
    chk("coll2_memN",  64'(memory_N), 64'h1);
    chk("coll2_mems",  64'(memory_s), 64'hB);
    chk("coll2_miss",  64'(miss_count), 64'd4);

    en = 1'b0;
    wr(1, 36'hF_FFFF_FFFF, 4'h6);
    wr(2, 36'hF_FFFF_FFFF, 4'h7);
    wr(5, 36'hF_FFFF_FFFF, 4'h7);
    wr(20, 36'h123, 4'h4);
    chk("en0_miss", 64'(miss_count), 64'd4);

    en = 1'b1; N = 36'hF_FFFF_FFFF; s = 4'h7;
    step();
    chk("dup_found", 64'(found), 64'd1);
    chk("dup_memN",  64'(memory_N), 64'hF_FFFF_FFFF);
    chk("dup_mems",  64'(memory_s), 64'h7);
    chk("dup_miss",  64'(miss_count), 64'd4);

    s = 4'h9;
    step();
    chk("pat_found", 64'(found), 64'd0);
    chk("pat_memN",  64'(memory_N), 64'hF_FFFF_FFFF);
    chk("pat_mems",  64'(memory_s), 64'h6);
    chk("pat_miss",  64'(miss_count), 64'd5);

    N = 36'h123; s = 4'h4;
    step();
    chk("oor_found", 64'(found), 64'd0);
    chk("oor_memN",  64'(memory_N), 64'd0);
    chk("oor_mems",  64'(memory_s), 64'd0);
    chk("oor_miss",  64'(miss_count), 64'd6);

    en = 1'b0;
    step();
    chk("hold_miss", 64'(miss_count), 64'd6);

    en = 1'b1;
    repeat (260) step();
    chk("sat_miss", 64'(miss_count), 64'd255);
    chk("sat_err",  64'(error), 64'd1);

    // Reset beats a simultaneous write and a counting miss.
    rst = 1'b1; wr_en = 1'b1; wr_addr = 0; wr_N = 36'h5; wr_s = 4'h5;
    N = 36'hF_FFFF_FFFF; s = 4'h7;
    step();
    rst = 1'b0; wr_en = 1'b0;
    chk("mrst_found", 64'(found), 64'd0);
    chk("mrst_memN",  64'(memory_N), 64'd0);
    chk("mrst_mems",  64'(memory_s), 64'd0);
    chk("mrst_miss",  64'(miss_count), 64'd0);
    chk("mrst_err",   64'(error), 64'd0);

    step();
    chk("cleared_found", 64'(found), 64'd0);
    chk("cleared_memN",  64'(memory_N), 64'd0);
    chk("cleared_miss",  64'(miss_count), 64'd1);
    chk("cleared_err",   64'(error), 64'd0);

    N = 36'h5; s = 4'h5;
    step();
    chk("rstwr_found", 64'(found), 64'd0);
    chk("rstwr_miss",  64'(miss_count), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
